// File: rtl/spi_adc_scanner.sv
// Round-robin scanner for AD7908/AD7918/AD7928 SPI ADCs.
// Runs the dummy power-up frames, then routes results by returned address.
module spi_adc_scanner #(
  parameter int CLK_DIV_HALF = 2500,
  parameter int NUM_CH       = 2,
  parameter int ADC_BITS     = 8,
  parameter int RANGE_BIT    = 1,
  parameter int QUIET_TICKS  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [NUM_CH-1:0]          ch_mask,
  output logic                       spi_sck,
  output logic                       spi_cs_n,
  output logic                       spi_mosi,
  input  logic                       spi_miso,
  output logic [NUM_CH*ADC_BITS-1:0] adc_data,
  output logic [NUM_CH-1:0]          adc_valid,
  output logic                       scan_done,
  output logic                       addr_err,
  output logic                       busy
);

  localparam int DW = (CLK_DIV_HALF > 1) ?
    $clog2(CLK_DIV_HALF) : 1;
  localparam int QW = (QUIET_TICKS > 1) ?
    $clog2(QUIET_TICKS) : 1;

  typedef enum logic [2:0] {
    INIT, IDLE, FRAME, QUIET, PROCESS
  } state_t;

  state_t state, state_nx;

  logic [DW-1:0] div;
  logic          tick;
  logic [5:0]    tcnt, tn;
  logic [QW-1:0] qcnt;
  logic [15:0]   txsr, rxsr, word;
  logic          init_ph, dcnt, first;
  logic [2:0]    last_addr, exp_addr;
  logic [2:0]    nxt, lo, up, hi, ra;
  logic          up_ok, start, hit;
  logic [7:0]    mask8;
  logic [ADC_BITS-1:0] val;
  logic          unused_rx;

  assign tick = (div == DW'(CLK_DIV_HALF - 1));
  assign tn   = tcnt + 6'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div <= '0;
    else if (tick) div <= '0;
    else           div <= div + 1'b1;
  end

  // Lowest enabled above the last address, else wrap to lowest.
  always_comb begin
    lo    = '0;
    up    = '0;
    up_ok = 1'b0;
    hi    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        lo = 3'(i);
        if (3'(i) > last_addr) begin
          up    = 3'(i);
          up_ok = 1'b1;
        end
      end
    end
    for (int i = 0; i < NUM_CH; i++)
      if (ch_mask[i]) hi = 3'(i);
    nxt = (up_ok && !first) ? up : lo;
  end

  assign word = {3'b100, nxt, 2'b11, 2'b00,
                 1'(RANGE_BIT), 1'b1, 4'b0000};

  assign mask8     = 8'(ch_mask);
  assign ra        = rxsr[14:12];
  assign val       = rxsr[11 -: ADC_BITS];
  assign hit       = (32'(ra) < NUM_CH) && mask8[ra];
  assign unused_rx = ^rxsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    busy     = 1'b0;
    unique case (state)
      INIT: begin
        if (tick) begin
          start    = 1'b1;
          state_nx = FRAME;
        end
      end
      IDLE: begin
        if (tick && enable && |ch_mask) begin
          start    = 1'b1;
          state_nx = FRAME;
        end
      end
      FRAME: begin
        busy = 1'b1;
        if (tick && tn == 6'd33) state_nx = QUIET;
      end
      QUIET: begin
        busy = 1'b1;
        if (tick && qcnt == QW'(QUIET_TICKS - 1))
          state_nx = PROCESS;
      end
      PROCESS: begin
        busy     = 1'b1;
        state_nx = (init_ph && !dcnt) ? INIT : IDLE;
      end
      default: state_nx = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_sck   <= 1'b1;
      spi_cs_n  <= 1'b1;
      spi_mosi  <= 1'b0;
      tcnt      <= '0;
      qcnt      <= '0;
      txsr      <= '0;
      rxsr      <= '0;
      init_ph   <= 1'b1;
      dcnt      <= 1'b0;
      first     <= 1'b1;
      last_addr <= '0;
      exp_addr  <= '0;
      adc_data  <= '0;
      adc_valid <= '0;
      scan_done <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      adc_valid <= '0;
      scan_done <= 1'b0;
      addr_err  <= 1'b0;
      if (start) begin
        spi_cs_n <= 1'b0;
        tcnt     <= '0;
        if (init_ph) begin
          txsr     <= 16'hFFFF;
          spi_mosi <= 1'b1;
        end else begin
          txsr      <= word;
          spi_mosi  <= word[15];
          exp_addr  <= last_addr;
          last_addr <= nxt;
          first     <= 1'b0;
        end
      end else if (state == FRAME && tick) begin
        tcnt <= tn;
        if (tn == 6'd33) begin
          spi_cs_n <= 1'b1;
          spi_mosi <= 1'b0;
          qcnt     <= '0;
        end else if (tn[0]) begin
          spi_sck <= 1'b0;
          rxsr    <= {rxsr[14:0], spi_miso};
        end else begin
          spi_sck  <= 1'b1;
          txsr     <= {txsr[14:0], 1'b0};
          spi_mosi <= txsr[14];
        end
      end else if (state == QUIET && tick) begin
        qcnt <= qcnt + 1'b1;
      end else if (state == PROCESS) begin
        if (init_ph) begin
          dcnt <= ~dcnt;
          if (dcnt) init_ph <= 1'b0;
        end else begin
          addr_err  <= (ra != exp_addr);
          scan_done <= hit && (ra == hi);
          for (int n = 0; n < NUM_CH; n++) begin
            if (hit && ra == 3'(n)) begin
              adc_data[n*ADC_BITS +: ADC_BITS] <= val;
              adc_valid[n] <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_adc_scanner.sv
// Randomized bench for spi_adc_scanner with an ADC model
// and a frame-level scoreboard.
module tb_spi_adc_scanner;

  localparam int D  = 2;
  localparam int NC = 4;
  localparam int AB = 10;
  localparam int Q  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic spi_miso = 1'b0;
  logic [NC-1:0] ch_mask = '0;
  logic spi_sck, spi_cs_n, spi_mosi;
  logic [NC*AB-1:0] adc_data;
  logic [NC-1:0] adc_valid;
  logic scan_done, addr_err, busy;

  spi_adc_scanner #(
    .CLK_DIV_HALF(D),
    .NUM_CH(NC),
    .ADC_BITS(AB),
    .RANGE_BIT(1),
    .QUIET_TICKS(Q)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .ch_mask(ch_mask),
    .spi_sck(spi_sck),
    .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .adc_data(adc_data),
    .adc_valid(adc_valid),
    .scan_done(scan_done),
    .addr_err(addr_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  logic [AB-1:0] slot [NC];
  int dummies, pend_cnt, proc_cnt, frames;
  int nfall, since, override, bidx;
  logic [2:0] adc_ptr, last_sent, prev_sent;
  logic [2:0] sent_exp, pend_exp;
  bit first, is_dummy;
  logic [15:0] rx_word, cur_frame, pend_frame;
  logic cs_p = 1'b1, sck_p = 1'b1, mosi_p = 1'b0;
  logic adc_cs_q = 1'b1;

  function automatic logic [2:0] next_ch(
    logic [NC-1:0] m, int last, bit from0);
    for (int k = 0; k < NC; k++) begin
      int c;
      c = from0 ? k : (last + 1 + k) % NC;
      if (m[c]) return 3'(c);
    end
    return 3'd0;
  endfunction

  function automatic int highest(logic [NC-1:0] m);
    int h;
    h = -1;
    for (int k = 0; k < NC; k++)
      if (m[k]) h = k;
    return h;
  endfunction

  function automatic logic [NC*AB-1:0] packed_slots();
    logic [NC*AB-1:0] r;
    for (int n = 0; n < NC; n++)
      r[n*AB +: AB] = slot[n];
    return r;
  endfunction

  task automatic model_reset();
    dummies   = 2;
    adc_ptr   = '0;
    last_sent = '0;
    prev_sent = '0;
    first     = 1'b1;
    pend_cnt  = -1;
    override  = -1;
    for (int n = 0; n < NC; n++) slot[n] = '0;
  endtask

  // ADC: shifts {0, addr, data} out, changing on SCK falls.
  always @(negedge spi_cs_n or posedge spi_cs_n
           or negedge spi_sck) begin
    if (!rst && adc_cs_q && !spi_cs_n) begin
      logic [2:0] ra;
      ra = (override >= 0) ? 3'(override) : adc_ptr;
      override  = -1;
      cur_frame = {1'b0, ra, 12'($urandom_range(0, 4095))};
      spi_miso  = cur_frame[15];
      bidx      = 14;
    end else if (!spi_cs_n && bidx >= 0) begin
      spi_miso = cur_frame[bidx];
      bidx--;
    end
    adc_cs_q = spi_cs_n;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (pend_cnt > 0) pend_cnt--;
      if (pend_cnt == 0) begin : proc
        int r;
        logic hit;
        r   = int'(pend_frame[14:12]);
        hit = (r < NC) ? ch_mask[r[1:0]] : 1'b0;
        check("valid", adc_valid,
              hit ? (64'd1 << r) : 64'd0);
        check("scan_done", scan_done,
              hit && r == highest(ch_mask));
        check("addr_err", addr_err,
              pend_frame[14:12] != pend_exp);
        if (hit)
          slot[r] = AB'(pend_frame[11:0] >> (12 - AB));
        check("data", adc_data, packed_slots());
        pend_cnt = -1;
        proc_cnt++;
      end else if (adc_valid != 0 || scan_done || addr_err)
        check("spurious_pulse",
              {adc_valid, scan_done, addr_err}, 0);
      if (cs_p && !spi_cs_n) begin
        frames++;
        nfall    = 0;
        since    = 0;
        rx_word  = '0;
        is_dummy = dummies > 0;
        if (!is_dummy)
          sent_exp = next_ch(ch_mask, int'(last_sent), first);
      end
      if (!spi_cs_n) begin
        since++;
        if (sck_p && !spi_sck) begin
          check("mosi_stable", spi_mosi, mosi_p);
          check("busy_frame", busy, 1);
          if (nfall > 0) check("sck_period", since, 2 * D);
          since   = 0;
          nfall++;
          rx_word = {rx_word[14:0], spi_mosi};
        end
      end
      if (!cs_p && spi_cs_n) begin
        check("fall_count", nfall, 16);
        if (is_dummy) begin
          check("dummy_word", rx_word, 16'hFFFF);
          dummies--;
          adc_ptr = '0;
        end else begin
          check("ctrl_word", rx_word,
                16'h8330 | (16'(sent_exp) << 10));
          pend_frame = cur_frame;
          pend_exp   = prev_sent;
          pend_cnt   = Q * D + 1;
          prev_sent  = sent_exp;
          last_sent  = sent_exp;
          first      = 1'b0;
          adc_ptr    = rx_word[12:10];
        end
      end
    end
    cs_p   = spi_cs_n;
    sck_p  = spi_sck;
    mosi_p = spi_mosi;
  end

  task automatic wait_proc(int n);
    int start, c;
    start = proc_cnt;
    c = 0;
    while (proc_cnt < start + n && c < 100 * n + 300) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("proc_timeout", proc_cnt >= start + n, 1);
  endtask

  task automatic wait_fall(int n);
    int c;
    c = 0;
    while (!(!spi_cs_n && nfall == n) && c < 400) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("fall_timeout", !spi_cs_n && nfall == n, 1);
  endtask

  initial begin
    int f;
    model_reset();
    proc_cnt = 0;
    frames   = 0;
    nfall    = 0;
    since    = 0;
    bidx     = -1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_sck", spi_sck, 1);
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_mosi", spi_mosi, 0);
    check("rst_data", adc_data, 0);
    check("rst_valid", adc_valid, 0);
    check("rst_done", scan_done, 0);
    check("rst_err", addr_err, 0);
    check("rst_busy", busy, 0);
    rst     = 1'b0;
    enable  = 1'b1;
    ch_mask = 4'b0011;
    wait_proc(6);
    ch_mask = 4'b1010;
    wait_proc(4);
    ch_mask = 4'b0111;
    wait_proc(1);
    for (int k = 0; k < 4 && last_sent != 3'd1; k++)
      wait_proc(1);
    override = 2;
    wait_proc(2);
    override = 6;
    wait_proc(2);
    for (int i = 0; i < 20; i++) begin
      wait_proc(1);
      if ($urandom_range(0, 2) == 0)
        ch_mask = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 3) == 0)
        override = $urandom_range(0, 7);
    end
    wait_fall(7);
    rst = 1'b1;
    #1;
    check("abort_cs_n", spi_cs_n, 1);
    check("abort_sck", spi_sck, 1);
    model_reset();
    ch_mask = 4'b1010;
    repeat (3) @(negedge clk);
    #1;
    check("abort_data", adc_data, 0);
    rst = 1'b0;
    wait_proc(4);
    check("slot0_zero", adc_data[0 +: AB], 0);
    check("slot2_zero", adc_data[2*AB +: AB], 0);
    wait_fall(5);
    enable = 1'b0;
    wait_proc(1);
    f = frames;
    repeat (300) @(negedge clk);
    #1;
    check("disabled_frames", frames - f, 0);
    check("disabled_busy", busy, 0);
    check("disabled_cs_n", spi_cs_n, 1);
    ch_mask = '0;
    enable  = 1'b1;
    f = frames;
    repeat (300) @(negedge clk);
    #1;
    check("nomask_frames", frames - f, 0);
    check("nomask_busy", busy, 0);
    ch_mask = 4'b1111;
    wait_proc(5);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
